mmcm_ps_arbiter: RTL

Shares one MMCM phase-shift step controller (signed 16-bit step index, load/done handshake) between `pNUM_REQ` requesters, such as glitch offset, glitch width and ADC capture-phase register blocks. Each requester posts a target step index with a one-cycle load pulse. The arbiter queues pending requests and grants them round-robin, one at a time. It holds the granted index stable on the shared port until the controller reports done, then returns a per-requester done pulse. A watchdog halts the arbiter if the controller never answers.

---
 rtl/mmcm_ps_arbiter_if.sv | 28 ++
 rtl/mmcm_ps_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mmcm_ps_arbiter_if.sv
// mmcm_ps_arbiter_if: requester bundle plus the shared
// phase-shift controller port of the arbiter.
interface mmcm_ps_arbiter_if #(
  parameter int pNUM_REQ = 3
);
  logic [16*pNUM_REQ-1:0] I_req_index;
  logic [pNUM_REQ-1:0]    I_req_load;
  logic [pNUM_REQ-1:0]    O_req_done;
  logic [pNUM_REQ-1:0]    O_req_pending;
  logic                   O_busy;
  logic                   O_error;
  logic                   I_clear_error;
  logic [15:0]            O_ps_step_index;
  logic                   O_ps_load;
  logic                   I_ps_done;

  modport master (
    output I_req_index, I_req_load, I_clear_error, I_ps_done,
    input  O_req_done, O_req_pending, O_busy, O_error,
    input  O_ps_step_index, O_ps_load
  );

  modport slave (
    input  I_req_index, I_req_load, I_clear_error, I_ps_done,
    output O_req_done, O_req_pending, O_busy, O_error,
    output O_ps_step_index, O_ps_load
  );
endinterface

// File: rtl/mmcm_ps_arbiter.sv
// mmcm_ps_arbiter: round-robin sharing of one MMCM phase-shift
// step controller between pNUM_REQ requesters, with watchdog.
module mmcm_ps_arbiter #(
  parameter int pNUM_REQ = 3,
  parameter int pTIMEOUT = 1000000
) (
  input  logic              clk_usb,
  input  logic              reset_n,
  mmcm_ps_arbiter_if.slave  bus
);
  localparam int GW = $clog2(pNUM_REQ);
  localparam logic [31:0] LIM =
    (pTIMEOUT == 0) ? 32'd0 : 32'(pTIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, WAIT, DONE, HALT
  } state_t;

  state_t state, state_n;

  logic [pNUM_REQ-1:0][15:0] target;
  logic [pNUM_REQ-1:0]       pending;
  logic [pNUM_REQ-1:0]       grant_oh;
  logic [pNUM_REQ-1:0]       cur_oh;
  logic [pNUM_REQ-1:0]       clr;
  logic [GW-1:0]             last_grant;
  logic [GW-1:0]             grant;
  logic [GW-1:0]             cur;
  logic [31:0]               wd_cnt;
  logic                      grant_vld;
  logic                      do_grant;
  logic                      expire;
  int                        cand;

  // Descending scan so the nearest requester after last_grant wins.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    cand      = 0;
    for (int i = pNUM_REQ; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % pNUM_REQ;
      if (pending[GW'(cand)]) begin
        grant     = GW'(cand);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  assign do_grant = (state == IDLE) && grant_vld;
  assign clr      = do_grant ? grant_oh : '0;
  assign expire   = (pTIMEOUT != 0) && (wd_cnt == LIM);

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (grant_vld) state_n = WAIT;
      WAIT: begin
        if (bus.I_ps_done)  state_n = DONE;
        else if (expire)    state_n = HALT;
      end
      DONE: state_n = IDLE;
      HALT: if (bus.I_clear_error) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      target              <= '0;
      pending             <= '0;
      last_grant          <= GW'(pNUM_REQ - 1);
      cur                 <= '0;
      cur_oh              <= '0;
      wd_cnt              <= '0;
      bus.O_ps_step_index <= '0;
      bus.O_ps_load       <= 1'b0;
      bus.O_req_done      <= '0;
      bus.O_busy          <= 1'b0;
      bus.O_error         <= 1'b0;
    end else begin
      for (int k = 0; k < pNUM_REQ; k++) begin
        if (bus.I_req_load[k])
          target[k] <= bus.I_req_index[16*k +: 16];
      end
      // a load landing on the grant cycle keeps its pending bit
      pending        <= (pending & ~clr) | bus.I_req_load;
      bus.O_ps_load  <= do_grant;
      bus.O_req_done <= '0;
      bus.O_busy     <= (state_n == WAIT) || (state_n == HALT);
      if (do_grant) begin
        bus.O_ps_step_index <= target[grant];
        cur                 <= grant;
        cur_oh              <= grant_oh;
        wd_cnt              <= '0;
      end else if (state == WAIT && wd_cnt != '1) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
      if (state == WAIT && bus.I_ps_done)
        bus.O_req_done <= cur_oh;
      if (state == DONE)
        last_grant <= cur;
      if (state == WAIT && !bus.I_ps_done && expire)
        bus.O_error <= 1'b1;
      else if (bus.I_clear_error)
        bus.O_error <= 1'b0;
    end
  end

  assign bus.O_req_pending = pending;

endmodule
